// File: rtl/move_command_scheduler.sv
// Turns one-hot direction levels into move commands (press + auto-repeat), queued in a FIFO, issued valid/ready.
// Latency: input change to move_valid is 2 cycles (enqueue edge, then output-register load edge).
// Backpressure: move_ready low holds the presented command; FIFO fills, and further enqueues are dropped with a pulse.
module move_command_scheduler #(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 26
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    step_option,
    input  logic [2:0]                    hold_option,
    output logic                          move_valid,
    output logic [1:0]                    move_dir,
    input  logic                          move_ready,
    output logic                          paused,
    output logic                          dropped,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [AW:0]      FULL_COUNT  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    // Registers
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_step_q;
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [1:0]       r_mem [FIFO_DEPTH];
    logic             r_valid;
    logic [1:0]       r_dir;
    logic             r_paused;
    logic             r_dropped;

    // Combinational nets
    state_t           w_nxt_state;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_enq;
    logic             w_onehot;
    logic             w_new_press;
    logic [1:0]       w_code;
    logic             w_pause;
    logic             w_flush;
    logic [AW:0]      w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_wr;
    logic             w_drop;
    logic             w_unused;

    // Hold switch bit 2 has no function.
    assign w_unused = hold_option[2];

    // Pause and flush act on the live switch levels, not the registered copy.
    assign w_pause = hold_option[0];
    assign w_flush = hold_option[1];

    // Anything not exactly one-hot (including all-zero) is a release.
    assign w_onehot    = (step_option != 4'b0000) && ((step_option & (step_option - 4'd1)) == 4'b0000);
    assign w_new_press = w_onehot && (step_option != r_step_q);

    // Map one-hot direction to command code.
    always_comb begin
        w_code = 2'd0;
        case (step_option)
            4'b0001: w_code = 2'd0;
            4'b0010: w_code = 2'd1;
            4'b0100: w_code = 2'd2;
            4'b1000: w_code = 2'd3;
            default: w_code = 2'd0;
        endcase
    end

    // Repeat FSM next-state: press enqueues, then delay, then periodic repeat while held.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_enq       = 1'b0;
        if (w_pause) begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_new_press) begin
                        w_enq       = 1'b1;
                        w_nxt_cnt   = '0;
                        w_nxt_state = S_DELAY;
                    end
                end
                S_DELAY, S_REPEAT: begin
                    if (!w_onehot) begin
                        w_nxt_state = S_IDLE;
                        w_nxt_cnt   = '0;
                    end else if (step_option != r_step_q) begin
                        // Direction changed without a release: a fresh press.
                        w_enq       = 1'b1;
                        w_nxt_cnt   = '0;
                        w_nxt_state = S_DELAY;
                    end else if ((r_state == S_DELAY) && (r_cnt == DELAY_LAST)) begin
                        w_enq       = 1'b1;
                        w_nxt_cnt   = '0;
                        w_nxt_state = S_REPEAT;
                    end else if ((r_state == S_REPEAT) && (r_cnt == PERIOD_LAST)) begin
                        w_enq       = 1'b1;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_nxt_cnt   = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Repeat FSM state, counter and previous-input register (step_q tracks input even while paused).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_step_q <= 4'b0000;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_step_q <= step_option;
        end
    end

    // FIFO status and write/pop decisions. A flush discards both the queue and this cycle's enqueue,
    // and also blocks the head from being loaded since it is being thrown away.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == FULL_COUNT);
    assign w_empty = (w_count == '0);
    assign w_pop   = !w_pause && !w_flush && !w_empty && (!r_valid || move_ready);
    assign w_wr    = w_enq && !w_flush && (!w_full || w_pop);
    assign w_drop  = w_enq && !w_flush && w_full && !w_pop;

    // FIFO storage; no reset needed since occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_code;
        end
    end

    // FIFO pointers, one wrap bit beyond the index to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Output register: load the head when free or being accepted, otherwise drop valid after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_dir   <= 2'd0;
        end else if (w_pop) begin
            r_valid <= 1'b1;
            r_dir   <= r_mem[r_rd_ptr[AW-1:0]];
        end else if (r_valid && move_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Status flags: registered pause copy and single-cycle drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_paused  <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_paused  <= hold_option[0];
            r_dropped <= w_drop;
        end
    end

    assign move_valid = r_valid;
    assign move_dir   = r_dir;
    assign paused     = r_paused;
    assign dropped    = r_dropped;
    assign fifo_count = w_count;

endmodule

// File: tb/tb_move_command_scheduler.sv
// Directed bench for move_command_scheduler: press, auto-repeat, fill/drop, full+pop, pause, flush.
// Inputs driven 1 time unit after the rising edge; outputs checked on the falling edge.
// Transfers and drop pulses are logged by a falling-edge monitor; tests compare against hand-derived lists.
module tb_move_command_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] step_option;
    logic [2:0] hold_option;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;
    logic       paused;
    logic       dropped;
    logic [2:0] fifo_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int drop_cnt    = 0;
    int xfer_dir[$];
    int xfer_cyc[$];

    move_command_scheduler #(
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4),
        .FIFO_DEPTH    (4),
        .CNT_W         (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .step_option (step_option),
        .hold_option (hold_option),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .move_ready  (move_ready),
        .paused      (paused),
        .dropped     (dropped),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // A transfer happens on the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        if (rst_n && move_valid && move_ready) begin
            xfer_dir.push_back(int'(move_dir));
            xfer_cyc.push_back(cyc);
        end
        if (rst_n && dropped) drop_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic press(input logic [3:0] d);
        step_option = d;
        @(posedge clk); #1;
        step_option = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; step_option = 4'b0000; hold_option = 3'b001; move_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", move_valid); end
        vectors++; if (move_dir !== 2'd0) begin miscompares++; $display("FAIL reset_dir: got %0d want 0", move_dir); end
        vectors++; if (paused !== 1'b0) begin miscompares++; $display("FAIL reset_paused: got %b want 0", paused); end
        vectors++; if (dropped !== 1'b0) begin miscompares++; $display("FAIL reset_dropped: got %b want 0", dropped); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        hold_option = 3'b000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_single_press;
        int base;
        base = xfer_dir.size();
        move_ready = 1'b1;
        step_option = 4'b0010;
        @(negedge clk);
        vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL press_valid_t0: got %b want 0", move_valid); end
        @(negedge clk);
        vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL press_count_t1: got %0d want 1", fifo_count); end
        vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL press_valid_t1: got %b want 0", move_valid); end
        @(negedge clk);
        vectors++; if (move_valid !== 1'b1 || move_dir !== 2'd1) begin miscompares++; $display("FAIL press_out_t2: got valid=%b dir=%0d want valid=1 dir=1", move_valid, move_dir); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL press_count_t2: got %0d want 0", fifo_count); end
        @(posedge clk); #1;
        step_option = 4'b0000;
        repeat (6) @(negedge clk);
        vectors++; if (xfer_dir.size() - base !== 1) begin miscompares++; $display("FAIL press_xfers: got %0d want 1", xfer_dir.size() - base); end
        vectors++; if (xfer_dir.size() > base && xfer_dir[base] !== 1) begin miscompares++; $display("FAIL press_dir: got %0d want 1", xfer_dir[base]); end
        vectors++; if (move_valid !== 1'b0 || fifo_count !== 3'd0) begin miscompares++; $display("FAIL press_idle: got valid=%b count=%0d want 0/0", move_valid, fifo_count); end
    endtask

    task automatic test_auto_repeat;
        int base;
        int c0;
        int exp_off[5];
        exp_off = '{2, 10, 14, 18, 22};
        @(posedge clk); #1;
        base = xfer_dir.size();
        c0 = cyc;
        move_ready = 1'b1;
        step_option = 4'b1000;
        repeat (21) @(posedge clk);
        #1;
        step_option = 4'b0000;
        repeat (30) @(posedge clk);
        #1;
        vectors++; if (xfer_dir.size() - base !== 5) begin miscompares++; $display("FAIL repeat_xfers: got %0d want 5", xfer_dir.size() - base); end
        for (int i = 0; i < 5; i++) begin
            int gd;
            int gc;
            gd = (base + i < xfer_dir.size()) ? xfer_dir[base + i] : -1;
            gc = (base + i < xfer_cyc.size()) ? xfer_cyc[base + i] - c0 : -1;
            vectors++; if (gd !== 3 || gc !== exp_off[i]) begin miscompares++; $display("FAIL repeat_xfer%0d: got dir=%0d at +%0d want dir=3 at +%0d", i, gd, gc, exp_off[i]); end
        end
    endtask

    task automatic test_fill_and_drop;
        int base;
        int d0;
        logic [3:0] seq[6];
        int exp_d[5];
        seq   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_d = '{0, 1, 2, 3, 0};
        move_ready = 1'b0;
        d0 = drop_cnt;
        for (int i = 0; i < 6; i++) begin
            press(seq[i]);
            vectors++; if (move_valid !== 1'b1 || move_dir !== 2'd0) begin miscompares++; $display("FAIL fill_hold%0d: got valid=%b dir=%0d want 1/0", i, move_valid, move_dir); end
        end
        @(negedge clk);
        vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL fill_count: got %0d want 4", fifo_count); end
        vectors++; if (drop_cnt - d0 !== 1) begin miscompares++; $display("FAIL fill_drops: got %0d want 1", drop_cnt - d0); end
        @(posedge clk); #1;
        base = xfer_dir.size();
        move_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        vectors++; if (xfer_dir.size() - base !== 5) begin miscompares++; $display("FAIL drain_xfers: got %0d want 5", xfer_dir.size() - base); end
        for (int i = 0; i < 5; i++) begin
            int gd;
            gd = (base + i < xfer_dir.size()) ? xfer_dir[base + i] : -1;
            vectors++; if (gd !== exp_d[i]) begin miscompares++; $display("FAIL drain_order%0d: got %0d want %0d", i, gd, exp_d[i]); end
        end
        vectors++; if (move_valid !== 1'b0 || fifo_count !== 3'd0) begin miscompares++; $display("FAIL drain_idle: got valid=%b count=%0d want 0/0", move_valid, fifo_count); end
    endtask

    task automatic test_full_with_pop;
        int base;
        int d0;
        logic [3:0] seq[5];
        int exp_d[6];
        seq   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_d = '{0, 1, 2, 3, 0, 2};
        move_ready = 1'b0;
        for (int i = 0; i < 5; i++) press(seq[i]);
        vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL fullpop_pre: got %0d want 4", fifo_count); end
        base = xfer_dir.size();
        d0 = drop_cnt;
        step_option = 4'b0100;
        move_ready  = 1'b1;
        @(posedge clk); #1;
        step_option = 4'b0000;
        move_ready  = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL fullpop_count: got %0d want 4", fifo_count); end
        vectors++; if (drop_cnt - d0 !== 0) begin miscompares++; $display("FAIL fullpop_drops: got %0d want 0", drop_cnt - d0); end
        @(posedge clk); #1;
        move_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        vectors++; if (xfer_dir.size() - base !== 6) begin miscompares++; $display("FAIL fullpop_xfers: got %0d want 6", xfer_dir.size() - base); end
        for (int i = 0; i < 6; i++) begin
            int gd;
            gd = (base + i < xfer_dir.size()) ? xfer_dir[base + i] : -1;
            vectors++; if (gd !== exp_d[i]) begin miscompares++; $display("FAIL fullpop_order%0d: got %0d want %0d", i, gd, exp_d[i]); end
        end
    endtask

    task automatic test_pause;
        int base;
        int exp_d[3];
        exp_d = '{0, 1, 2};
        move_ready = 1'b0;
        press(4'b0001); press(4'b0010); press(4'b0100);
        vectors++; if (fifo_count !== 3'd2 || move_valid !== 1'b1) begin miscompares++; $display("FAIL pause_pre: got count=%0d valid=%b want 2/1", fifo_count, move_valid); end
        base = xfer_dir.size();
        hold_option = 3'b001;
        move_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL pause_valid: got %b want 0", move_valid); end
        vectors++; if (paused !== 1'b1) begin miscompares++; $display("FAIL pause_flag: got %b want 1", paused); end
        @(posedge clk); #1;
        press(4'b1000);
        repeat (2) @(negedge clk);
        vectors++; if (fifo_count !== 3'd2 || move_valid !== 1'b0) begin miscompares++; $display("FAIL pause_ignore: got count=%0d valid=%b want 2/0", fifo_count, move_valid); end
        @(posedge clk); #1;
        hold_option = 3'b000;
        repeat (8) @(posedge clk);
        #1;
        vectors++; if (paused !== 1'b0) begin miscompares++; $display("FAIL pause_clear: got %b want 0", paused); end
        vectors++; if (xfer_dir.size() - base !== 3) begin miscompares++; $display("FAIL pause_xfers: got %0d want 3", xfer_dir.size() - base); end
        for (int i = 0; i < 3; i++) begin
            int gd;
            gd = (base + i < xfer_dir.size()) ? xfer_dir[base + i] : -1;
            vectors++; if (gd !== exp_d[i]) begin miscompares++; $display("FAIL pause_order%0d: got %0d want %0d", i, gd, exp_d[i]); end
        end
    endtask

    task automatic test_flush;
        int base;
        int d0;
        move_ready = 1'b0;
        press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
        vectors++; if (fifo_count !== 3'd3) begin miscompares++; $display("FAIL flush_pre: got %0d want 3", fifo_count); end
        base = xfer_dir.size();
        d0 = drop_cnt;
        hold_option = 3'b010;
        @(posedge clk); #1;
        hold_option = 3'b000;
        @(negedge clk);
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL flush_count: got %0d want 0", fifo_count); end
        vectors++; if (move_valid !== 1'b1 || move_dir !== 2'd0) begin miscompares++; $display("FAIL flush_out: got valid=%b dir=%0d want 1/0", move_valid, move_dir); end
        @(posedge clk); #1;
        move_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (xfer_dir.size() - base !== 1) begin miscompares++; $display("FAIL flush_xfers: got %0d want 1", xfer_dir.size() - base); end
        vectors++; if (xfer_dir.size() > base && xfer_dir[base] !== 0) begin miscompares++; $display("FAIL flush_dir: got %0d want 0", xfer_dir[base]); end
        vectors++; if (drop_cnt - d0 !== 0) begin miscompares++; $display("FAIL flush_drops: got %0d want 0", drop_cnt - d0); end
        vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL flush_idle: got %b want 0", move_valid); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_auto_repeat();
        test_fill_and_drop();
        test_full_with_pop();
        test_pause();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/move_command_scheduler.md
# move_command_scheduler

Sits between the button debouncer and the game/stepping engine. Turns debounced one-hot direction levels into discrete move commands: one command per press, auto-repeat while held. Commands are buffered in a small FIFO and issued over a valid/ready handshake. Applies the debounced hold switches as pause and flush controls.

## Interface
Parameters:
- REPEAT_DELAY, default 50_000_000: cycles from a press to the first auto-repeat command; must be ≥ 2.
- REPEAT_PERIOD, default 10_000_000: cycles between later auto-repeat commands; must be ≥ 2.
- FIFO_DEPTH, default 4: command FIFO entries; power of two, ≥ 2.
- CNT_W, default 26: repeat counter width; must hold max(REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- step_option  in  4  debounced direction level, one-hot: 0001 U, 0010 L, 0100 R, 1000 D.
- hold_option  in  3  debounced switches: bit0 pause, bit1 flush, bit2 ignored.
- move_valid  out  1  a command is presented.
- move_dir  out  2  command code: U=0, L=1, R=2, D=3.
- move_ready  in  1  engine accepts the command.
- paused  out  1  registered copy of hold_option[0].
- dropped  out  1  one-cycle pulse when an enqueue is lost because the FIFO is full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy; excludes the output register.

## Operation
- Reset (asynchronous, active-low) values: move_valid=0, move_dir=0, paused=0, dropped=0, fifo_count=0. Also FIFO pointers=0, step_q=0, repeat FSM=IDLE, repeat counter=0.
- step_q holds the registered previous step_option. A step_option value that is not one-hot, including 0000, counts as released.
- Repeat FSM, states IDLE, DELAY, REPEAT:
  - IDLE: on a one-hot step_option ≠ step_q, enqueue its code, clear the counter, go to DELAY.
  - DELAY: counter increments. When counter == REPEAT_DELAY-1, enqueue, clear the counter, go to REPEAT.
  - REPEAT: when counter == REPEAT_PERIOD-1, enqueue and clear the counter.
  - DELAY/REPEAT, released: go to IDLE with no enqueue.
  - DELAY/REPEAT, a different one-hot direction: treat as a new press. Enqueue the new code, clear the counter, go to DELAY.
- Pause (hold_option[0]=1):
  - FSM is forced to IDLE and nothing is enqueued.
  - No new command is loaded into the output register.
  - A command already presented stays valid until accepted.
  - step_q keeps tracking input, so a direction held through the pause is not enqueued on resume; only a fresh press is.
- Flush (hold_option[1]=1): FIFO pointers reset, so fifo_count becomes 0 next cycle. Enqueues that cycle are discarded without pulsing dropped. The output register is not cleared.
- FIFO write:
  - Succeeds if not full, or if full and a pop happens the same cycle.
  - Otherwise the command is discarded and dropped pulses.
  - At most one enqueue per cycle.
- Output register:
  - Loads the FIFO head (pop) when it is empty or being accepted (move_valid & move_ready), the FIFO is non-empty, and not paused.
  - move_valid drops after acceptance when nothing is loaded.
- Handshake: while move_valid=1 and move_ready=0, move_dir and move_valid hold stable. Transfer occurs on a cycle with both high.

## Timing
- A press at edge k writes the FIFO, and fifo_count updates after k. The output register loads at k+1, so move_valid is high after k+1: 2 cycles from input change to command.
- Back-to-back throughput: one command per cycle with move_ready held high.
- First repeat enqueue at edge k+REPEAT_DELAY, then every REPEAT_PERIOD cycles while held.
- paused is registered: it follows hold_option[0] one cycle later, but gating acts on the unregistered input the same cycle.
- Full and pop on the same edge: the write is accepted and fifo_count is unchanged.
- Asynchronous reset mid-handshake drops the presented command; no recovery.

## Test plan
Bench parameters: REPEAT_DELAY=8, REPEAT_PERIOD=4, FIFO_DEPTH=4, CNT_W=4.
- Reset, move_ready=1, step_option=0010 for 3 cycles then 0000 -> exactly one transfer, move_dir=1, valid 2 cycles after the input change; fifo_count returns to 0.
- step_option=1000 held 20 cycles, move_ready=1 -> transfers (dir=3) at press, press+8, press+12, press+16, press+20 (±pipeline 2); none after release.
- move_ready=0, presses U, L, R, D, U, L, each separated by 0000 -> move_valid=1 with dir=0 held stable. fifo_count=4 (L, R, D, U). The final press (L) pulses dropped once. Raise ready -> order 0, 1, 2, 3, 0.
- FIFO full, move_ready=1 for one cycle coinciding with a new press R -> no dropped pulse; fifo_count stays 4, with R at the tail.
- hold_option=001 with 2 queued and 1 presented -> the presented command transfers, then move_valid=0 and presses are ignored. Clear the pause -> the 2 queued commands issue.
- 3 queued, hold_option=010 for 1 cycle -> fifo_count=0 next cycle; the presented command still completes; no dropped pulse.
